// File: rtl/seq_div_pkg.sv
// Shared constants and state encoding for the sequential restoring divider.
// Optional feature macro used by seq_div: DIV_FAST_EXIT_EN.
package seq_div_pkg;

  typedef enum logic [1:0] {
    DivFree   = 2'd0,
    DivByZero = 2'd1,
    DivOn     = 2'd2,
    DivEnd    = 2'd3
  } div_state_e;

  localparam logic        DivStart          = 1'b1;
  localparam logic        DivStop           = 1'b0;
  localparam logic        DivResultReady    = 1'b1;
  localparam logic        DivResultNotReady = 1'b0;
  localparam logic [31:0] ZeroWord          = 32'h0000_0000;

endpackage

// File: rtl/seq_div_div_step.sv
// One combinational radix-2 restoring iteration: shift in the next dividend
// bit, subtract the divisor when it fits, and report the quotient bit.
module div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem_i,
  input  logic             dvd_bit_i,
  input  logic [WIDTH-1:0] dvs_i,
  output logic [WIDTH-1:0] rem_o,
  output logic             q_bit_o
);

  logic [WIDTH:0] partial;

  // Trial subtraction; rem_i < dvs_i always holds, so the difference fits WIDTH bits.
  always_comb begin
    partial = {rem_i, dvd_bit_i};
    q_bit_o = (partial >= {1'b0, dvs_i});
    rem_o   = q_bit_o ? (partial[WIDTH-1:0] - dvs_i) : partial[WIDTH-1:0];
  end

endmodule

// File: rtl/seq_div.sv
// Multi-cycle radix-2 restoring divider for the EX stage (start/ready handshake).
// Returns {remainder, quotient}. Optional macro DIV_FAST_EXIT_EN skips the
// iterations when |dividend| < |divisor|.
module seq_div
  import seq_div_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               signed_div_i,
  input  logic [WIDTH-1:0]   opdata1_i,
  input  logic [WIDTH-1:0]   opdata2_i,
  input  logic               start_i,
  input  logic               annul_i,
  output logic [2*WIDTH-1:0] result_o,
  output logic               ready_o
);

  localparam int CntW = $clog2(WIDTH) + 1;

  div_state_e           state_q, state_d;
  logic [CntW-1:0]      cnt_q, cnt_d;
  logic [WIDTH-1:0]     dvd_q, dvd_d;   // dividend magnitude, becomes quotient as it shifts
  logic [WIDTH-1:0]     dvs_q, dvs_d;   // divisor magnitude
  logic [WIDTH-1:0]     rem_q, rem_d;   // partial remainder
  logic                 negq_q, negq_d;
  logic                 negr_q, negr_d;
  logic [2*WIDTH-1:0]   result_q, result_d;
  logic                 ready_q, ready_d;
`ifdef DIV_FAST_EXIT_EN
  logic                 fast_q, fast_d;
`endif

  logic [WIDTH-1:0]     dvd_mag, dvs_mag;
  logic [WIDTH-1:0]     step_rem;
  logic                 step_q;
  logic [WIDTH-1:0]     quo_next;
  logic                 go;
  logic                 abort;

  function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v, input logic sgn);
    logic signed [WIDTH-1:0] s;
    s = signed'(v);
    return (sgn && s[WIDTH-1]) ? -s : s;
  endfunction

  function automatic logic [WIDTH-1:0] apply_sign(input logic [WIDTH-1:0] mag, input logic neg);
    logic signed [WIDTH-1:0] s;
    s = signed'(mag);
    return neg ? -s : s;
  endfunction

  div_step #(.WIDTH(WIDTH)) u_step (
    .rem_i     (rem_q),
    .dvd_bit_i (dvd_q[WIDTH-1]),
    .dvs_i     (dvs_q),
    .rem_o     (step_rem),
    .q_bit_o   (step_q)
  );

  // Operand magnitudes and handshake qualifiers derived from the live inputs.
  always_comb begin
    dvd_mag  = magnitude(opdata1_i, signed_div_i);
    dvs_mag  = magnitude(opdata2_i, signed_div_i);
    quo_next = {dvd_q[WIDTH-2:0], step_q};
    go       = (start_i == DivStart) && !annul_i;
    abort    = annul_i || (start_i == DivStop);
  end

  // Next-state logic of the divide FSM.
  always_comb begin
    state_d = state_q;
    case (state_q)
      DivFree: begin
        if (go) begin
          if (opdata2_i == '0) begin
            state_d = DivByZero;
`ifdef DIV_FAST_EXIT_EN
          end else if (dvd_mag < dvs_mag) begin
            state_d = DivByZero;
`endif
          end else begin
            state_d = DivOn;
          end
        end
      end
      DivByZero: state_d = abort ? DivFree : DivEnd;
      DivOn: begin
        if (abort)                         state_d = DivFree;
        else if (cnt_q == CntW'(WIDTH-1))  state_d = DivEnd;
      end
      DivEnd:  if (abort) state_d = DivFree;
      default: state_d = DivFree;
    endcase
  end

  // Datapath and registered-output next values for each state.
  always_comb begin
    cnt_d    = cnt_q;
    dvd_d    = dvd_q;
    dvs_d    = dvs_q;
    rem_d    = rem_q;
    negq_d   = negq_q;
    negr_d   = negr_q;
    result_d = result_q;
    ready_d  = ready_q;
`ifdef DIV_FAST_EXIT_EN
    fast_d   = fast_q;
`endif
    case (state_q)
      DivFree: begin
        result_d = '0;
        ready_d  = DivResultNotReady;
        if (go) begin
          cnt_d  = '0;
          dvd_d  = dvd_mag;
          dvs_d  = dvs_mag;
          rem_d  = '0;
          negq_d = signed_div_i && (opdata1_i[WIDTH-1] ^ opdata2_i[WIDTH-1]);
          negr_d = signed_div_i && opdata1_i[WIDTH-1];
`ifdef DIV_FAST_EXIT_EN
          // Fast exit keeps the dividend unchanged as the remainder.
          fast_d = (opdata2_i != '0) && (dvd_mag < dvs_mag);
          rem_d  = fast_d ? opdata1_i : '0;
`endif
        end
      end
      DivByZero: begin
        result_d = '0;
`ifdef DIV_FAST_EXIT_EN
        if (state_d == DivEnd && fast_q) result_d = {rem_q, {WIDTH{1'b0}}};
`endif
      end
      DivOn: begin
        rem_d = step_rem;
        dvd_d = quo_next;
        cnt_d = cnt_q + 1'b1;
        if (state_d == DivEnd)
          result_d = {apply_sign(step_rem, negr_q), apply_sign(quo_next, negq_q)};
        else if (state_d == DivFree)
          result_d = '0;
      end
      DivEnd: begin
        if (state_d == DivFree) begin
          result_d = '0;
          ready_d  = DivResultNotReady;
        end else begin
          ready_d  = DivResultReady;
        end
      end
      default: begin
        result_d = '0;
        ready_d  = DivResultNotReady;
      end
    endcase
  end

  // Control and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= DivFree;
      cnt_q    <= '0;
      result_q <= '0;
      ready_q  <= DivResultNotReady;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
      ready_q  <= ready_d;
    end
  end

  // Operand, remainder and sign registers; only meaningful after a start.
  always_ff @(posedge clk) begin
    dvd_q  <= dvd_d;
    dvs_q  <= dvs_d;
    rem_q  <= rem_d;
    negq_q <= negq_d;
    negr_q <= negr_d;
`ifdef DIV_FAST_EXIT_EN
    fast_q <= fast_d;
`endif
  end

  assign result_o = result_q;
  assign ready_o  = ready_q;

endmodule

// File: tb/tb_seq_div.sv
// Directed testbench for seq_div (WIDTH=32) with immediate-assertion checks.
module tb_seq_div;

  logic        clk = 1'b0;
  logic        rst;
  logic        signed_div_i;
  logic [31:0] opdata1_i;
  logic [31:0] opdata2_i;
  logic        start_i;
  logic        annul_i;
  logic [63:0] result_o;
  logic        ready_o;

  int n_vec = 0;
  int n_err = 0;

`ifdef DIV_FAST_EXIT_EN
  localparam int FastLat = 2;
`else
  localparam int FastLat = 33;
`endif

  seq_div #(.WIDTH(32)) dut (
    .clk          (clk),
    .rst          (rst),
    .signed_div_i (signed_div_i),
    .opdata1_i    (opdata1_i),
    .opdata2_i    (opdata2_i),
    .start_i      (start_i),
    .annul_i      (annul_i),
    .result_o     (result_o),
    .ready_o      (ready_o)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_ready(output int n);
    n = 0;
    while (ready_o !== 1'b1 && n < 200) begin
      tick();
      n++;
    end
  endtask

  // Full handshake: start held until ready, hold check, then release.
  task automatic run_div(input string tag, input logic sd, input logic [31:0] a,
                         input logic [31:0] b, input int lat, input logic [63:0] exp);
    int n;
    signed_div_i = sd;
    opdata1_i    = a;
    opdata2_i    = b;
    start_i      = 1'b1;
    tick();
    wait_ready(n);
    check({tag, " latency"}, 64'(n), 64'(lat));
    check({tag, " result"}, result_o, exp);
    opdata1_i = ~a;
    opdata2_i = 32'h5;
    tick();
    check({tag, " hold"}, {result_o[62:0], ready_o}, {exp[62:0], 1'b1});
    start_i = 1'b0;
    tick();
    check({tag, " release"}, {63'd0, ready_o} | result_o, 64'd0);
  endtask

  initial begin
    int n;
    int seen;
    rst = 1'b1; signed_div_i = 1'b0; opdata1_i = '0; opdata2_i = '0;
    start_i = 1'b0; annul_i = 1'b0;
    tick(); tick();
    check("reset ready", 64'(ready_o), 64'd0);
    check("reset result", result_o, 64'd0);
    rst = 1'b0;
    tick();

    run_div("u100/7", 1'b0, 32'd100, 32'd7, 33, {32'd2, 32'd14});
    run_div("s-7/2", 1'b1, 32'hFFFF_FFF9, 32'd2, 33, {32'hFFFF_FFFF, 32'hFFFF_FFFD});
    run_div("s7/-2", 1'b1, 32'd7, 32'hFFFF_FFFE, 33, {32'd1, 32'hFFFF_FFFD});
    run_div("smin/-1", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 33, {32'd0, 32'h8000_0000});
    run_div("umin/max", 1'b0, 32'h8000_0000, 32'hFFFF_FFFF, FastLat, {32'h8000_0000, 32'd0});
    run_div("u/0", 1'b0, 32'd1234, 32'd0, 2, 64'd0);
    run_div("s/0", 1'b1, 32'hFFFF_FFFB, 32'd0, 2, 64'd0);
    run_div("u3/10", 1'b0, 32'd3, 32'd10, FastLat, {32'd3, 32'd0});

    // Annul during iteration 10 while start stays high: restart with new operands.
    signed_div_i = 1'b0; opdata1_i = 32'd100; opdata2_i = 32'd7; start_i = 1'b1;
    tick();
    for (int i = 0; i < 10; i++) tick();
    annul_i = 1'b1; opdata1_i = 32'd9; opdata2_i = 32'd3;
    tick();
    check("annul ready", 64'(ready_o), 64'd0);
    annul_i = 1'b0;
    wait_ready(n);
    check("annul restart latency", 64'(n), 64'd34);
    check("annul restart result", result_o, {32'd0, 32'd3});
    start_i = 1'b0;
    tick();

    // Reset mid-iteration behaves like an annul.
    opdata1_i = 32'd100; opdata2_i = 32'd7; start_i = 1'b1;
    tick();
    for (int i = 0; i < 10; i++) tick();
    rst = 1'b1; opdata1_i = 32'd9; opdata2_i = 32'd3;
    tick();
    check("rst mid ready", 64'(ready_o), 64'd0);
    check("rst mid result", result_o, 64'd0);
    rst = 1'b0;
    wait_ready(n);
    check("rst restart latency", 64'(n), 64'd34);
    check("rst restart result", result_o, {32'd0, 32'd3});

    // Annul while in END returns to IDLE with outputs cleared.
    annul_i = 1'b1;
    tick();
    check("annul end", {63'd0, ready_o} | result_o, 64'd0);
    annul_i = 1'b0; start_i = 1'b0;
    tick();

    // Annul held in IDLE blocks start; release starts a full divide.
    opdata1_i = 32'd9; opdata2_i = 32'd3; start_i = 1'b1; annul_i = 1'b1;
    tick(); tick(); tick();
    check("annul idle block", 64'(ready_o), 64'd0);
    annul_i = 1'b0;
    wait_ready(n);
    check("after annul idle latency", 64'(n), 64'd34);
    start_i = 1'b0;
    tick();

    // Dropping start during iteration aborts; ready never rises.
    opdata1_i = 32'd100; opdata2_i = 32'd7; start_i = 1'b1;
    tick();
    for (int i = 0; i < 5; i++) tick();
    start_i = 1'b0;
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (ready_o !== 1'b0) seen++;
    end
    check("start drop abort", 64'(seen), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
